// File: rtl/miner_pkg.sv
// Shared constants and types for the miner CSR master.
// CSR map, control/status bit positions and FSM state encoding.
package miner_pkg;

  localparam int MESSAGE_SIZE = 608;
  localparam int TARGET_SIZE  = 256;

  localparam logic [4:0] CTRL_ADDR   = 5'd1;
  localparam logic [4:0] TARGET_BASE = 5'd2;
  localparam logic [4:0] MSG_BASE    = 5'd11;
  localparam logic [4:0] NONCE_ADDR  = 5'd30;
  localparam logic [4:0] STATUS_ADDR = 5'd31;

  localparam int CTRL_NEW_TARGET = 0;
  localparam int CTRL_NEW_MSG    = 1;
  localparam int STAT_FOUND      = 0;
  localparam int STAT_COMPLETE   = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_TGT,
    S_WR_MSG,
    S_CTRL_SET,
    S_CTRL_CLR,
    S_WAIT,
    S_POLL,
    S_CAP,
    S_RD_NONCE,
    S_CAP_N,
    S_DONE
  } state_e;

endpackage

// File: rtl/csr_poll_timer.sv
// Loadable down-counter pacing status reads of the CSR slave.
// zero_o is high while the count is 0; the count holds at 0.
module csr_poll_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] value_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // load has priority over counting down
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/miner_csr_master.sv
// Avalon-MM master writing a mining job into the CSR slave and polling it.
// Optional abort on timeout: define MINER_CSR_MASTER_TIMEOUT_EN.
module miner_csr_master
  import miner_pkg::*;
#(
  parameter int NUM_TARGET_WORDS = 8,
  parameter int NUM_MSG_WORDS    = 19,
  parameter int POLL_INTERVAL    = 16,
  parameter int TIMEOUT_CYCLES   = 2**24
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic                    job_load_target,
  input  logic [TARGET_SIZE-1:0]  job_target,
  input  logic [MESSAGE_SIZE-1:0] job_msg,
  output logic                    res_valid,
  output logic                    res_found,
  output logic                    res_timeout,
  output logic [31:0]             res_nonce,
  output logic [4:0]              m_address,
  output logic [31:0]             m_writedata,
  output logic                    m_write,
  output logic                    m_read,
  output logic                    m_chipselect,
  input  logic [31:0]             m_readdata
);

  localparam logic [4:0]  TGT_LAST  = 5'(NUM_TARGET_WORDS - 1);
  localparam logic [4:0]  MSG_LAST  = 5'(NUM_MSG_WORDS - 1);
  // WAIT spends exactly POLL_INTERVAL cycles: counts LOAD..0
  localparam logic [15:0] POLL_LOAD = 16'(POLL_INTERVAL - 1);

  state_e                  state_q, state_d;
  logic [4:0]              idx_q, idx_d;
  logic [TARGET_SIZE-1:0]  tgt_q, tgt_d;
  logic [MESSAGE_SIZE-1:0] msg_q, msg_d;
  logic                    lt_q, lt_d;
  logic                    found_q, found_d;
  logic                    tout_q, tout_d;
  logic [31:0]             nonce_q, nonce_d;
  logic                    tmr_load, tmr_en, tmr_zero;
  logic                    tout_hit;
  logic                    polling;

  assign polling = (state_q == S_WAIT) || (state_q == S_POLL) ||
                   (state_q == S_CAP);

`ifdef MINER_CSR_MASTER_TIMEOUT_EN
  logic [31:0] tcnt_q;

  // cycles elapsed since the control clear write
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tcnt_q <= '0;
    end else if (state_q == S_CTRL_CLR) begin
      tcnt_q <= 32'd1;
    end else if (polling && !tout_hit) begin
      tcnt_q <= tcnt_q + 32'd1;
    end
  end

  assign tout_hit = polling && (tcnt_q >= 32'(TIMEOUT_CYCLES));
`else
  assign tout_hit = 1'b0;
`endif

  csr_poll_timer #(.W(16)) u_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .load_i  (tmr_load),
    .en_i    (tmr_en),
    .value_i (POLL_LOAD),
    .zero_o  (tmr_zero)
  );

  // next-state, bus strobes and result capture
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tgt_d       = tgt_q;
    msg_d       = msg_q;
    lt_d        = lt_q;
    found_d     = found_q;
    tout_d      = tout_q;
    nonce_d     = nonce_q;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;
    job_ready   = 1'b0;
    res_valid   = 1'b0;
    m_address   = '0;
    m_writedata = '0;
    m_write     = 1'b0;
    m_read      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          tgt_d   = job_target;
          msg_d   = job_msg;
          lt_d    = job_load_target;
          idx_d   = '0;
          state_d = job_load_target ? S_WR_TGT : S_WR_MSG;
        end
      end
      S_WR_TGT: begin
        m_write     = 1'b1;
        m_address   = TARGET_BASE + idx_q;
        m_writedata = tgt_q[31:0];
        tgt_d       = tgt_q >> 32;
        if (idx_q == TGT_LAST) begin
          idx_d   = '0;
          state_d = S_WR_MSG;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      S_WR_MSG: begin
        m_write     = 1'b1;
        m_address   = MSG_BASE + idx_q;
        m_writedata = msg_q[31:0];
        msg_d       = msg_q >> 32;
        if (idx_q == MSG_LAST) begin
          state_d = S_CTRL_SET;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      S_CTRL_SET: begin
        m_write     = 1'b1;
        m_address   = CTRL_ADDR;
        m_writedata = {30'b0, 1'b1, lt_q};
        state_d     = S_CTRL_CLR;
      end
      S_CTRL_CLR: begin
        m_write  = 1'b1;
        m_address = CTRL_ADDR;
        tmr_load = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (tout_hit) begin
          state_d = S_DONE;
        end else if (tmr_zero) begin
          state_d = S_POLL;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_POLL: begin
        m_read    = 1'b1;
        m_address = STATUS_ADDR;
        state_d   = tout_hit ? S_DONE : S_CAP;
      end
      S_CAP: begin
        if (m_readdata[STAT_COMPLETE]) begin
          if (m_readdata[STAT_FOUND]) begin
            state_d = S_RD_NONCE;
          end else begin
            found_d = 1'b0;
            tout_d  = 1'b0;
            nonce_d = '0;
            state_d = S_DONE;
          end
        end else if (tout_hit) begin
          state_d = S_DONE;
        end else begin
          tmr_load = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_RD_NONCE: begin
        m_read    = 1'b1;
        m_address = NONCE_ADDR;
        state_d   = S_CAP_N;
      end
      S_CAP_N: begin
        found_d = 1'b1;
        tout_d  = 1'b0;
        nonce_d = m_readdata;
        state_d = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // a timeout abandons the job with an empty result
    if (tout_hit && !(state_q == S_CAP && m_readdata[STAT_COMPLETE])) begin
      found_d = 1'b0;
      tout_d  = 1'b1;
      nonce_d = '0;
    end
  end

  assign m_chipselect = m_write | m_read;
  assign res_found    = found_q;
  assign res_timeout  = tout_q;
  assign res_nonce    = nonce_q;

  // state and datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tgt_q   <= '0;
      msg_q   <= '0;
      lt_q    <= 1'b0;
      found_q <= 1'b0;
      tout_q  <= 1'b0;
      nonce_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tgt_q   <= tgt_d;
      msg_q   <= msg_d;
      lt_q    <= lt_d;
      found_q <= found_d;
      tout_q  <= tout_d;
      nonce_q <= nonce_d;
    end
  end

endmodule

// File: tb/tb_miner_csr_master.sv
// Scoreboard bench for miner_csr_master with a behavioural CSR slave.
// Job vectors come from a table; reset/back-to-back/timeout are hand-written.
module tb_miner_csr_master;
  import miner_pkg::*;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         job_valid;
  logic         job_ready;
  logic         job_load_target;
  logic [255:0] job_target;
  logic [607:0] job_msg;
  logic         res_valid, res_found, res_timeout;
  logic [31:0]  res_nonce;
  logic [4:0]   m_address;
  logic [31:0]  m_writedata;
  logic         m_write, m_read, m_chipselect;
  logic [31:0]  m_readdata = '0;

  always #5 clk = ~clk;

  miner_csr_master #(.TIMEOUT_CYCLES(100)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_load_target (job_load_target),
    .job_target      (job_target),
    .job_msg         (job_msg),
    .res_valid       (res_valid),
    .res_found       (res_found),
    .res_timeout     (res_timeout),
    .res_nonce       (res_nonce),
    .m_address       (m_address),
    .m_writedata     (m_writedata),
    .m_write         (m_write),
    .m_read          (m_read),
    .m_chipselect    (m_chipselect),
    .m_readdata      (m_readdata)
  );

  typedef struct {
    logic        wr;
    logic [4:0]  a;
    logic [31:0] d;
  } bus_t;

  typedef struct {
    logic        lt;
    logic [31:0] tbase;
    logic [31:0] tstep;
    logic [31:0] mbase;
    logic [31:0] mstep;
    int          npolls;
    logic        found;
    logic [31:0] nonce;
  } vec_t;

  bus_t        exp_q[$];
  int          st_times[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          clr_cyc = 0;
  int          n_res = 0;
  int          st_reads = 0;
  int          st_base = 0;
  int          cfg_npolls = 0;
  logic        cfg_found = 1'b0;
  logic [31:0] cfg_nonce = '0;
  bit          ign = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // CSR slave model: read data appears the cycle after m_read
  always @(posedge clk) begin
    if (m_read) begin
      if (m_address == 5'd31) begin
        if (st_reads - st_base < cfg_npolls) m_readdata <= 32'd0;
        else m_readdata <= {30'b0, 1'b1, cfg_found};
        st_reads <= st_reads + 1;
      end else if (m_address == 5'd30) begin
        m_readdata <= cfg_nonce;
      end else begin
        m_readdata <= 32'hBAD0_BAD0;
      end
    end
  end

  // bus monitor against the scoreboard
  always @(negedge clk) begin
    if (n_rst === 1'b1 && (m_write || m_read)) begin
      chk("chipselect", m_chipselect, 1);
      chk("ready_busy", job_ready, 0);
      if (m_read && m_address == 5'd31) st_times.push_back(cyc);
      if (m_write && m_address == 5'd1 && m_writedata == 0) clr_cyc = cyc;
      if (!ign) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bus", {m_write, m_address}, 0);
        end else begin
          bus_t e;
          e = exp_q.pop_front();
          chk("bus_kind", m_write, e.wr);
          chk("bus_addr", m_address, e.a);
          if (e.wr) chk("bus_wdata", m_writedata, e.d);
        end
      end
    end
    if (n_rst === 1'b1 && res_valid) n_res = n_res + 1;
  end

  task automatic push_w(input logic [4:0] a, input logic [31:0] d);
    bus_t e;
    e.wr = 1'b1; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_r(input logic [4:0] a);
    bus_t e;
    e.wr = 1'b0; e.a = a; e.d = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_job(input vec_t v);
    if (v.lt)
      for (int k = 0; k < 8; k++) push_w(5'(2 + k), v.tbase + 32'(k) * v.tstep);
    for (int k = 0; k < 19; k++) push_w(5'(11 + k), v.mbase + 32'(k) * v.mstep);
    push_w(5'd1, {30'b0, 1'b1, v.lt});
    push_w(5'd1, 32'd0);
    for (int i = 0; i <= v.npolls; i++) push_r(5'd31);
    if (v.found) push_r(5'd30);
  endtask

  task automatic set_job(input vec_t v);
    job_load_target = v.lt;
    for (int k = 0; k < 8; k++) job_target[32*k +: 32] = v.tbase + 32'(k) * v.tstep;
    for (int k = 0; k < 19; k++) job_msg[32*k +: 32] = v.mbase + 32'(k) * v.mstep;
  endtask

  task automatic set_slave(input vec_t v);
    st_base    = st_reads;
    cfg_npolls = v.npolls;
    cfg_found  = v.found;
    cfg_nonce  = v.nonce;
  endtask

  task automatic wait_res(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("res_valid_timeout", 0, 1);
  endtask

  task automatic check_res(input vec_t v, input int st0);
    chk("res_found", res_found, v.found);
    chk("res_nonce", res_nonce, v.found ? v.nonce : 32'd0);
    chk("res_timeout", res_timeout, 0);
    chk("queue_empty", exp_q.size(), 0);
    chk("status_reads", st_times.size() - st0, v.npolls + 1);
    if (st_times.size() > st0)
      chk("first_poll_gap", st_times[st0] - clr_cyc, 17);
    for (int i = st0 + 1; i < st_times.size(); i++)
      chk("poll_spacing", st_times[i] - st_times[i-1], 18);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    int st0;
    st0 = st_times.size();
    set_slave(v);
    push_job(v);
    set_job(v);
    job_valid = 1'b1;
    @(posedge clk);
    #1 job_valid = 1'b0;
    wait_res(3000, ok);
    if (ok) check_res(v, st0);
    @(negedge clk);
    chk("res_one_cycle", res_valid, 0);
    chk("ready_after", job_ready, 1);
    chk("res_hold_found", res_found, v.found);
  endtask

  vec_t vecs[4];

  initial begin
    bit ok;
    int st0, nres0;
    vec_t va, vb;

    vecs[0] = '{1'b1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1, 2, 1'b1, 32'h0000_1234};
    vecs[1] = '{1'b0, 32'd0, 32'd0, 32'd100, 32'd3, 0, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 32'hA500_0000, 32'd1, 32'h1000_0000, 32'h11, 1, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 32'd0, 32'd0, 32'h8000_0001, 32'h8000_0000, 3, 1'b1, 32'h0};

    n_rst = 1'b0;
    job_valid = 1'b0;
    job_load_target = 1'b0;
    job_target = '0;
    job_msg = '0;
    #1;
    chk("rst_ready", job_ready, 1);
    chk("rst_write", m_write, 0);
    chk("rst_read", m_read, 0);
    chk("rst_cs", m_chipselect, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_found", res_found, 0);
    chk("rst_res_nonce", res_nonce, 0);
    chk("rst_res_timeout", res_timeout, 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // job_valid held high: second job only after DONE, first not re-sampled
    va = '{1'b1, 32'h1111_0000, 32'd1, 32'h2222_0000, 32'd1, 1, 1'b0, 32'h0};
    vb = '{1'b0, 32'd0, 32'd0, 32'h3333_0000, 32'd2, 0, 1'b1, 32'h55AA};
    st0 = st_times.size();
    set_slave(va);
    push_job(va);
    push_job(vb);
    set_job(va);
    job_valid = 1'b1;
    @(posedge clk);
    #1 set_job(vb);
    wait_res(3000, ok);
    if (ok) begin
      chk("hold_a_found", res_found, 0);
      chk("hold_a_nonce", res_nonce, 0);
      chk("hold_ready_done", job_ready, 0);
      set_slave(vb);
      @(negedge clk);
      chk("hold_ready_idle", job_ready, 1);
      @(posedge clk);
      #1 job_valid = 1'b0;
      wait_res(3000, ok);
      if (ok) begin
        chk("hold_b_found", res_found, 1);
        chk("hold_b_nonce", res_nonce, 32'h55AA);
        chk("hold_queue", exp_q.size(), 0);
      end
    end
    job_valid = 1'b0;
    @(negedge clk);

    // reset during message word 7 aborts at once
    ign = 1'b1;
    exp_q.delete();
    set_slave(vecs[0]);
    set_job(vecs[0]);
    job_valid = 1'b1;
    @(posedge clk);
    #1 job_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_write && m_address == 5'd18) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reached_msg7", ok, 1);
    nres0 = n_res;
    #1 n_rst = 1'b0;
    #1;
    chk("abort_write", m_write, 0);
    chk("abort_cs", m_chipselect, 0);
    chk("abort_ready", job_ready, 1);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_res", n_res - nres0, 0);
    ign = 1'b0;
    run_vec(vecs[0]);

    // status never completes
    ign = 1'b1;
    va = '{1'b0, 32'd0, 32'd0, 32'h7, 32'd1, 1000000, 1'b0, 32'h0};
    set_slave(va);
    set_job(va);
    st0 = st_times.size();
    nres0 = n_res;
    job_valid = 1'b1;
    @(posedge clk);
    #1 job_valid = 1'b0;
`ifdef MINER_CSR_MASTER_TIMEOUT_EN
    wait_res(500, ok);
    if (ok) begin
      chk("tout_flag", res_timeout, 1);
      chk("tout_found", res_found, 0);
      chk("tout_nonce", res_nonce, 0);
      chk("tout_time", cyc - clr_cyc, 101);
    end
`else
    repeat (1100) @(negedge clk);
    chk("no_tout_res", n_res - nres0, 0);
    chk("no_tout_polling", (st_times.size() - st0) >= 50, 1);
    chk("no_tout_flag", res_timeout, 0);
`endif
    n_rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
